// File: rtl/polilock_pkg.sv
//==============================================================================
// Package     : polilock_pkg
// Description : Key codes, function codes and entrada_senha state encodings
//               shared by the lock front end and the control unit.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package polilock_pkg;

    localparam logic [3:0] TECLA_VERIFICA  = 4'hA;
    localparam logic [3:0] TECLA_CONFIGURA = 4'hB;
    localparam logic [3:0] TECLA_LIMPA     = 4'hC;
    localparam logic [3:0] TECLA_APAGA     = 4'hD;
    localparam logic [3:0] TECLA_MAX_DIGITO = 4'h9;

    localparam logic [1:0] FUNC_NENHUMA      = 2'b00;
    localparam logic [1:0] FUNC_VERIFICACAO  = 2'b01;
    localparam logic [1:0] FUNC_CONFIGURACAO = 2'b10;

    typedef enum logic [1:0] {
        ST_COLETA   = 2'd0,
        ST_COMPLETO = 2'd1,
        ST_ENVIADO  = 2'd2
    } estado_t;

    function automatic logic eh_digito(input logic [3:0] codigo);
        return (codigo <= TECLA_MAX_DIGITO);
    endfunction

endpackage

`default_nettype wire

// File: rtl/buffer_digitos.sv
//==============================================================================
// Module      : buffer_digitos
// Description : SENHA_LEN x 4-bit digit stack with push, pop (clears the
//               vacated slot), clear and a combinational read port.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module buffer_digitos
    import polilock_pkg::*;
#(
    parameter int SENHA_LEN = 4,
    parameter int AW        = $clog2(SENHA_LEN)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          i_push,
    input  logic          i_pop,
    input  logic          i_clear,
    input  logic [3:0]    i_push_data,
    input  logic [AW-1:0] i_rd_addr,
    output logic [3:0]    o_rd_data,
    output logic [AW:0]   o_n_digitos
);

    localparam logic [AW:0] c_LEN = (AW+1)'(SENHA_LEN);

    logic [3:0]  r_mem [SENHA_LEN];
    logic [AW:0] r_count;

    // Occupancy saturates at both ends so callers cannot over/underflow it.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_push && (r_count < c_LEN)) begin
            r_count <= r_count + 1'b1;
        end else if (i_pop && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < SENHA_LEN; i++) begin
                r_mem[i] <= 4'h0;
            end
        end else begin
            for (int i = 0; i < SENHA_LEN; i++) begin
                if (i_clear) begin
                    r_mem[i] <= 4'h0;
                end else if (i_push && (r_count == (AW+1)'(i))) begin
                    r_mem[i] <= i_push_data;
                end else if (i_pop && (r_count == (AW+1)'(i + 1))) begin
                    r_mem[i] <= 4'h0;
                end
            end
        end
    end

    // Out-of-range addresses match no slot and fall through to zero.
    always_comb begin
        o_rd_data = 4'h0;
        for (int i = 0; i < SENHA_LEN; i++) begin
            if (i_rd_addr == AW'(i)) begin
                o_rd_data = r_mem[i];
            end
        end
    end

    assign o_n_digitos = r_count;

endmodule

`default_nettype wire

// File: rtl/entrada_senha.sv
//==============================================================================
// Module      : entrada_senha
// Description : Keypad front end: collects password digits, decodes function
//               keys and holds the request until the control unit consumes it.
//               Optional idle timeout: `define ENTRADA_TIMEOUT_EN
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module entrada_senha
    import polilock_pkg::*;
#(
    parameter int SENHA_LEN      = 4,
    parameter int TIMEOUT_CYCLES = 50_000_000,
    parameter int AW             = $clog2(SENHA_LEN)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          key_valid,
    input  logic [3:0]    key_code,
    input  logic          consumido,
    input  logic          travado,
    input  logic [AW-1:0] rd_addr,
    output logic [3:0]    rd_data,
    output logic [1:0]    funcao,
    output logic          funcao_selecionada,
    output logic [AW:0]   n_digitos,
    output logic          tecla_invalida,
    output logic [1:0]    db_estado
);

    localparam logic [AW:0] c_ULTIMO = (AW+1)'(SENHA_LEN - 1);

    estado_t     r_estado;
    logic [1:0]  r_funcao;
    logic        r_selecionada;
    logic        r_invalida;

    estado_t     w_prox_estado;
    logic [1:0]  w_prox_funcao;
    logic        w_prox_selecionada;
    logic        w_rejeita;
    logic        w_push;
    logic        w_pop;
    logic        w_clear;
    logic        w_aceita;
    logic        w_timeout;
    logic [AW:0] w_n;

    assign w_aceita = key_valid && !travado;

    buffer_digitos #(
        .SENHA_LEN (SENHA_LEN),
        .AW        (AW)
    ) u_buffer (
        .clock       (clock),
        .reset       (reset),
        .i_push      (w_push),
        .i_pop       (w_pop),
        .i_clear     (w_clear),
        .i_push_data (key_code),
        .i_rd_addr   (rd_addr),
        .o_rd_data   (rd_data),
        .o_n_digitos (w_n)
    );

`ifdef ENTRADA_TIMEOUT_EN
    localparam int          c_TW        = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_TW-1:0] c_TO_FIM = c_TW'(TIMEOUT_CYCLES - 1);

    logic [c_TW-1:0] r_ocioso;
    logic            w_conta;

    assign w_conta   = !travado && (r_estado != ST_ENVIADO) && (w_n != '0);
    assign w_timeout = w_conta && !w_aceita && (r_ocioso == c_TO_FIM);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_ocioso <= '0;
        end else if (!w_conta || w_aceita || w_timeout) begin
            r_ocioso <= '0;
        end else begin
            r_ocioso <= r_ocioso + 1'b1;
        end
    end
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT_CYCLES == 0);
    assign w_timeout        = 1'b0;
`endif

    always_comb begin
        w_prox_estado      = r_estado;
        w_prox_funcao      = r_funcao;
        w_prox_selecionada = r_selecionada;
        w_rejeita          = 1'b0;
        w_push             = 1'b0;
        w_pop              = 1'b0;
        w_clear            = 1'b0;

        case (r_estado)
            ST_COLETA: begin
                if (w_aceita) begin
                    if (eh_digito(key_code)) begin
                        w_push = 1'b1;
                        if (w_n == c_ULTIMO) begin
                            w_prox_estado = ST_COMPLETO;
                        end
                    end else if (key_code == TECLA_APAGA) begin
                        w_pop = (w_n != '0);
                    end else if (key_code == TECLA_LIMPA) begin
                        w_clear = 1'b1;
                    end else begin
                        w_rejeita = 1'b1;
                    end
                end else if (w_timeout) begin
                    w_clear   = 1'b1;
                    w_rejeita = 1'b1;
                end
            end

            ST_COMPLETO: begin
                if (w_aceita) begin
                    case (key_code)
                        TECLA_VERIFICA: begin
                            w_prox_funcao      = FUNC_VERIFICACAO;
                            w_prox_selecionada = 1'b1;
                            w_prox_estado      = ST_ENVIADO;
                        end
                        TECLA_CONFIGURA: begin
                            w_prox_funcao      = FUNC_CONFIGURACAO;
                            w_prox_selecionada = 1'b1;
                            w_prox_estado      = ST_ENVIADO;
                        end
                        TECLA_APAGA: begin
                            w_pop         = 1'b1;
                            w_prox_estado = ST_COLETA;
                        end
                        TECLA_LIMPA: begin
                            w_clear       = 1'b1;
                            w_prox_estado = ST_COLETA;
                        end
                        default: w_rejeita = 1'b1;
                    endcase
                end else if (w_timeout) begin
                    w_clear       = 1'b1;
                    w_rejeita     = 1'b1;
                    w_prox_estado = ST_COLETA;
                end
            end

            ST_ENVIADO: begin
                // The ack takes priority and swallows any coincident key.
                if (consumido) begin
                    w_clear            = 1'b1;
                    w_prox_funcao      = FUNC_NENHUMA;
                    w_prox_selecionada = 1'b0;
                    w_prox_estado      = ST_COLETA;
                end else if (w_aceita && (key_code != TECLA_LIMPA)) begin
                    w_rejeita = 1'b1;
                end
            end

            default: begin
                w_clear            = 1'b1;
                w_prox_funcao      = FUNC_NENHUMA;
                w_prox_selecionada = 1'b0;
                w_prox_estado      = ST_COLETA;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_estado      <= ST_COLETA;
            r_funcao      <= FUNC_NENHUMA;
            r_selecionada <= 1'b0;
            r_invalida    <= 1'b0;
        end else begin
            r_estado      <= w_prox_estado;
            r_funcao      <= w_prox_funcao;
            r_selecionada <= w_prox_selecionada;
            r_invalida    <= w_rejeita;
        end
    end

    assign funcao             = r_funcao;
    assign funcao_selecionada = r_selecionada;
    assign tecla_invalida     = r_invalida;
    assign n_digitos          = w_n;
    assign db_estado          = r_estado;

endmodule

`default_nettype wire
